// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : boot_pkg
//  Description : Shared definitions for the instruction-memory boot loader:
//                load state encoding and stream framing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Load sequencing states
  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } boot_state_e;

  localparam int HDR_BYTES  = 4;                    // length field bytes
  localparam int WORD_BYTES = 4;                    // bytes per memory word
  localparam int CSUM_W     = 8;                    // checksum width
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);   // byte-in-word index width

endpackage
`default_nettype wire

// File: rtl/boot_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : boot_byte_packer
//  Description : Collects accepted bytes into little-endian 32-bit words.
//                word_valid is a combinational pulse on the cycle the 4th
//                byte of a word is accepted; word is valid in that cycle.
//  Ports       :
//    clk        in   system clock
//    areset     in   synchronous active-high reset
//    byte_en    in   a byte is being accepted this cycle
//    byte_data  in   accepted byte
//    byte_idx   out  position of the next byte inside the current word
//    word_valid out  4th byte of a word accepted this cycle
//    word       out  assembled word {byte3, byte2, byte1, byte0}
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_byte_packer
  import boot_pkg::*;
(
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic                  word_valid,
  output logic [31:0]           word
);

  // Holds the three earlier bytes of the word; newest byte enters at the top
  // so that after three bytes the buffer reads {byte2, byte1, byte0}.
  logic [23:0] shift_buf;

  always_ff @(posedge clk) begin
    if (areset) begin
      byte_idx  <= '0;
      shift_buf <= '0;
    end else if (byte_en) begin
      byte_idx  <= byte_idx + BYTE_IDX_W'(1);
      shift_buf <= {byte_data, shift_buf[23:8]};
    end
  end

  assign word_valid = byte_en && (byte_idx == BYTE_IDX_W'(WORD_BYTES - 1));
  assign word       = {byte_data, shift_buf};

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Fills the instruction memory from a byte stream
//                (4-byte LE word count N, N LE words, 1 checksum byte) and
//                holds the core in reset until a verified image is loaded.
//                Optional macro IMEM_BOOT_TIMEOUT_EN adds an inter-byte
//                timeout that forces the error state.
//  Ports       :
//    clk        in   system clock, rising edge
//    areset     in   synchronous active-high reset
//    in_valid   in   byte-stream valid
//    in_data    in   byte-stream data
//    in_ready   out  block can accept a byte
//    imem_we    out  instruction memory write strobe (one cycle per word)
//    imem_addr  out  word address of the write
//    imem_wdata out  word to write
//    core_hold  out  core held in reset while high
//    done       out  image loaded and verified (sticky)
//    error      out  load failed (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  // Wide enough to hold DEPTH itself so a full-size image never wraps.
  localparam int CNT_W = $clog2(DEPTH + 1);

  boot_state_e             state, state_next;
  logic                    accept;
  logic                    packer_en;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  logic                    word_valid;
  logic [31:0]             word;
  logic                    len_done;
  logic                    last_word;
  logic                    timeout_hit;
  logic [CNT_W-1:0]        word_cnt;
  logic [CNT_W-1:0]        n_last;     // index of the final data word
  logic [CSUM_W-1:0]       csum;

  assign accept    = in_valid && in_ready;
  // The packer assembles both the length field and the data words.
  assign packer_en = accept && ((state == LEN) || (state == DATA));

  boot_byte_packer u_packer (
    .clk        (clk),
    .areset     (areset),
    .byte_en    (packer_en),
    .byte_data  (in_data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word       (word)
  );

  assign len_done  = (state == LEN) && word_valid &&
                     (byte_idx == BYTE_IDX_W'(HDR_BYTES - 1));
  assign last_word = (state == DATA) && word_valid && (word_cnt == n_last);

`ifdef IMEM_BOOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            idle_tick;

  // Idle time only counts once a load has actually started.
  assign idle_tick   = !accept &&
                       (((state == LEN) && (byte_idx != '0)) ||
                        (state == DATA) || (state == CSUM));
  assign timeout_hit = idle_tick && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (areset || accept || (state == DONE) || (state == ERR)) begin
      idle_cnt <= '0;
    end else if (idle_tick) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_sig;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_sig = ^{byte_idx, 1'(TIMEOUT_CYCLES)};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= LEN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      LEN: begin
        if (len_done) begin
          if (word > 32'(DEPTH)) begin
            state_next = ERR;
          end else if (word == 32'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (last_word) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          state_next = (in_data == csum) ? DONE : ERR;
        end
      end
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
    if (timeout_hit) begin
      state_next = ERR;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (areset) begin
      word_cnt   <= '0;
      n_last     <= '0;
      csum       <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;

      // N has already been bounded by DEPTH when it is used, so the
      // truncation keeps every meaningful bit.
      if (len_done) begin
        n_last <= CNT_W'(word - 32'd1);
      end

      if ((state == DATA) && accept) begin
        csum <= csum + in_data;
      end

      if ((state == DATA) && word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= ADDR_W'(word_cnt);
        imem_wdata <= word;
        word_cnt   <= word_cnt + CNT_W'(1);
      end

      in_ready  <= (state_next == LEN) || (state_next == DATA) ||
                   (state_next == CSUM);
      core_hold <= (state_next != DONE);
      done      <= (state_next == DONE);
      error     <= (state_next == ERR);
    end
  end

endmodule
`default_nettype wire
